rand_scheduler: RTL and testbench

RAND_SCHEDULER -- requirements
Module: rand_scheduler

---
 rtl/rand_pkg.sv | 30 +++
 rtl/lfsr8_core.sv | 38 +++
 rtl/rand_scheduler.sv | 139 +++++++++++++
 tb/tb_rand_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the random-number scheduler: LFSR geometry,
// feedback taps, zero-seed substitute and controller state encoding.
package rand_pkg;

  localparam int LFSR_W = 8;

  // Fibonacci feedback taps (bit positions of the 8-bit state)
  localparam int TAP_0 = 7;
  localparam int TAP_1 = 5;
  localparam int TAP_2 = 4;
  localparam int TAP_3 = 3;

  // An all-zero state would lock the LFSR, so a zero seed loads this instead
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'h01;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WARM     = 2'd2,
    ST_SERVE    = 2'd3
  } sched_state_e;

  // One Fibonacci step: shift left, feedback enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR. load has priority over step; a zero seed is
// replaced so the register can never enter the all-zero lock-up state.
module lfsr8_core
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] state_out
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next state: load (with zero substitution), step, or hold
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed_in == '0) ? ZERO_SEED_SUB : seed_in;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // Shift register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ZERO_SEED_SUB;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: rtl/rand_scheduler.sv
// Hands out LFSR values to N_REQ requesters under round-robin arbitration.
//
// state     | meaning
// UNSEEDED  | after reset; no grants until a seed is loaded
// LOAD      | one cycle: latched seed written into the LFSR
// WARM      | LFSR steps once per cycle for WARMUP cycles, no grants
// SERVE     | one grant per cycle max; LFSR steps only on a grant
module rand_scheduler
  import rand_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WARMUP = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_load,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [LFSR_W-1:0] rnd,
  output logic              rnd_valid,
  output logic              ready
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e      state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [LFSR_W-1:0] rnd_q, rnd_d;
  logic [LFSR_W-1:0] seed_q, seed_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_state;

  logic              found;
  logic [PTR_W-1:0]  win;
  int                j;

  lfsr8_core u_lfsr (
    .clk       (clk),
    .clr       (clr),
    .load      (lfsr_load),
    .step      (lfsr_step),
    .seed_in   (seed_q),
    .state_out (lfsr_state)
  );

  // Round-robin search starting at the pointer, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      j = int'(ptr_q) + i;
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      if (!found && req[PTR_W'(j)]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
  end

  // Sequencing: reseed preempts everything, then per-state behaviour
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    rnd_d     = rnd_q;
    seed_d    = seed_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (seed_load) begin
      state_d = ST_LOAD;
      seed_d  = seed;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_UNSEEDED: ;
        ST_LOAD: begin
          lfsr_load = 1'b1;
          if (WARMUP == 0) begin
            state_d = ST_SERVE;
          end else begin
            state_d = ST_WARM;
            cnt_d   = 8'(WARMUP);
          end
        end
        ST_WARM: begin
          lfsr_step = 1'b1;
          if (cnt_q <= 8'd1) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_SERVE: begin
          if (found) begin
            gnt_d[win] = 1'b1;
            lfsr_step  = 1'b1;
            rnd_d      = lfsr_next(lfsr_state);
            ptr_d      = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          end
        end
        default: state_d = ST_UNSEEDED;
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_UNSEEDED;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      seed_q  <= seed_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign rnd_valid = |gnt_q;
  assign ready     = (state_q == ST_SERVE);

endmodule

// File: tb/tb_rand_scheduler.sv
// Directed bench for rand_scheduler with a cycle-level reference model.
module tb_rand_scheduler;

  localparam int N  = 4;
  localparam int WU = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         seed_load = 1'b0;
  logic [7:0]   seed = 8'h00;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [7:0]   rnd;
  logic         rnd_valid;
  logic         ready;

  int vectors = 0;
  int miscompares = 0;

  rand_scheduler #(.N_REQ(N), .WARMUP(WU)) dut (
    .clk       (clk),
    .clr       (clr),
    .seed      (seed),
    .seed_load (seed_load),
    .req       (req),
    .gnt       (gnt),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 unseeded, 1 loading, 2 warming, 3 serving
  int           m_phase = 0;
  int           m_left  = 0;
  int           m_ptr   = 0;
  int           k;
  logic [7:0]   m_seed  = 8'h00;
  logic [7:0]   m_lfsr  = 8'h01;
  logic [7:0]   m_rnd   = 8'h00;
  logic [N-1:0] m_gnt   = '0;
  logic [7:0]   warm_log[$];

  function automatic logic [7:0] step8(input logic [7:0] s);
    return (s << 1) | 8'(($countones(s & 8'hB8)) & 1);
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_phase = 0; m_left = 0; m_ptr = 0;
      m_lfsr = 8'h01; m_rnd = 8'h00; m_gnt = '0;
    end else begin
      m_gnt = '0;
      if (seed_load) begin
        m_seed = seed; m_phase = 1; m_ptr = 0;
      end else if (m_phase == 1) begin
        m_lfsr = (m_seed == 8'h00) ? 8'h01 : m_seed;
        warm_log.delete();
        m_left = WU;
        m_phase = (WU == 0) ? 3 : 2;
      end else if (m_phase == 2) begin
        m_lfsr = step8(m_lfsr);
        warm_log.push_back(m_lfsr);
        m_left--;
        if (m_left == 0) m_phase = 3;
      end else if (m_phase == 3) begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (req[k]) begin
            m_gnt[k] = 1'b1;
            m_lfsr = step8(m_lfsr);
            m_rnd = m_lfsr;
            m_ptr = (k + 1) % N;
            break;
          end
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("rnd", 32'(rnd), 32'(m_rnd));
    chk("rnd_valid", 32'(rnd_valid), 32'(m_gnt != '0));
    chk("ready", 32'(ready), 32'(m_phase == 3));
  end

  task automatic seed_pulse(input logic [7:0] s);
    @(posedge clk); #2;
    seed = s; seed_load = 1'b1;
    @(posedge clk); #2;
    seed_load = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 40) begin
        vectors++; miscompares++;
        $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", n);
        break;
      end
    end
  endtask

  logic [7:0]   wexp[8];
  logic [N-1:0] rr_exp[5];
  logic [7:0]   rnd_exp[5];
  logic [N-1:0] got_g[5];
  logic [7:0]   got_r[5];
  int           n;
  int           ngr;

  initial begin
    wexp    = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rnd_exp = '{8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89};

    #1 clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rnd", 32'(rnd), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    @(posedge clk); #2 clr = 1'b1;

    // request held off while unseeded and warming
    repeat (2) @(posedge clk); #2 req = 4'b0100;
    repeat (3) @(negedge clk);
    chk("unseeded_gnt", 32'(gnt), 32'h0);

    // seed 01: warm-up trail, ready latency, held request served first
    seed_pulse(8'h01);
    wait_ready(n);
    chk("ready_latency", 32'(n), 32'd9);
    chk("warm_len", 32'(warm_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < warm_log.size(); i++)
      chk("warm_state", 32'(warm_log[i]), 32'(wexp[i]));
    @(negedge clk);
    chk("held_gnt", 32'(gnt), 32'(4'b0100));
    chk("first_rnd", 32'(rnd), 32'h38);
    req = '0;

    // zero seed behaves as seed 01; round-robin over all four
    seed_pulse(8'h00);
    req = 4'b1111;
    wait_ready(n);
    chk("ready_latency0", 32'(n), 32'd9);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      got_g[g] = gnt;
      got_r[g] = rnd;
    end
    req = '0;
    for (int g = 0; g < 5; g++) begin
      chk("rr_gnt", 32'(got_g[g]), 32'(rr_exp[g]));
      chk("rr_rnd", 32'(got_r[g]), 32'(rnd_exp[g]));
      if (g > 0) chk("rnd_changes", 32'(got_r[g] != got_r[g-1]), 32'd1);
    end

    // reseed colliding with a request: no grant, rnd holds
    @(posedge clk); #2;
    req = 4'b0001; seed = 8'h5A; seed_load = 1'b1;
    @(posedge clk); #2;
    seed_load = 1'b0; req = '0;
    @(negedge clk);
    chk("collide_gnt", 32'(gnt), 32'h0);
    chk("collide_rnd", 32'(rnd), 32'h89);
    chk("collide_ready", 32'(ready), 32'h0);

    // reset in the middle of service
    wait_ready(n);
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h0);
    chk("midrst_rnd", 32'(rnd), 32'h0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    ngr = 0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != '0) ngr++;
    end
    chk("post_rst_grants", 32'(ngr), 32'd0);

    // reseed after reset: pointer back at 0
    seed_pulse(8'h01);
    wait_ready(n);
    @(negedge clk);
    chk("reseed_gnt", 32'(gnt), 32'(4'b0001));
    chk("reseed_rnd", 32'(rnd), 32'h38);
    req = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
